// File: rtl/pattgen16.sv
// pattgen16: burst generator of 16-bit counter/LFSR/walking-one/checkerboard words over valid/ready.
// Optional y_chk/err inverter checker is enabled with `define PATTGEN_CHECK_EN.
module pattgen16 #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    output logic [15:0]      y,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
`ifdef PATTGEN_CHECK_EN
    input  logic [15:0]      y_chk,
    output logic             err,
`endif
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'h0001 : SEED;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [15:0]      y_q, y_d, first_pat, next_pat;
    logic             xfer, accept;

    assign xfer   = (state_q == RUN) && ready;
    assign accept = (state_q == IDLE) && start;
    assign first_pat = (mode == 2'd0) ? 16'h0000 :
                       (mode == 2'd1) ? SEED_EFF :
                       (mode == 2'd2) ? 16'h0001 : 16'hAAAA;
    // y itself is the LFSR state, so every mode advances from y_q
    assign next_pat  = (mode_q == 2'd0) ? y_q + 16'd1 :
                       (mode_q == 2'd1) ? ({1'b0, y_q[15:1]} ^ (y_q[0] ? 16'hB400 : 16'h0000)) :
                       (mode_q == 2'd2) ? {y_q[14:0], y_q[15]} : ~y_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        y_d     = y_q;
        case (state_q)
            IDLE: if (start) begin
                mode_d  = mode;
                rem_d   = len;
                state_d = (len != '0) ? RUN : DONE;
                y_d     = (len != '0) ? first_pat : y_q;
            end
            RUN: if (ready) begin
                rem_d   = rem_q - LEN_W'(1);
                state_d = (rem_q == LEN_W'(1)) ? DONE : RUN;
                y_d     = (rem_q == LEN_W'(1)) ? y_q : next_pat;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            rem_q   <= '0;
            y_q     <= 16'h0000;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            y_q     <= y_d;
        end
    end

    assign y     = y_q;
    assign valid = (state_q == RUN);
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

`ifdef PATTGEN_CHECK_EN
    logic err_q, err_d;
    assign err_d = accept ? 1'b0 : ((xfer && (y_chk != ~y_q)) ? 1'b1 : err_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign err = err_q;
`else
    logic unused_accept;
    assign unused_accept = accept ^ xfer;
`endif
endmodule

// File: tb/tb_pattgen16.sv
// tb_pattgen16: directed self-checking bench for pattgen16, one task per scenario.
module tb_pattgen16;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  len = 8'd0;
    logic [15:0] y;
    logic        valid, busy, done;
    int          total = 0, bad = 0;
`ifdef PATTGEN_CHECK_EN
    logic [15:0] y_chk, g_y;
    logic        err, chk_bad = 1'b0;
    assign g_y   = ~y;
    assign y_chk = chk_bad ? 16'h0000 : g_y;
`endif

    pattgen16 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .len(len),
        .y(y), .valid(valid), .ready(ready), .busy(busy),
`ifdef PATTGEN_CHECK_EN
        .y_chk(y_chk), .err(err),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [1:0] m, input logic [7:0] l);
        mode = m; len = l; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({y, valid, busy, done} !== 19'h0) begin
            bad++; $display("FAIL reset y=%h v=%b b=%b d=%b exp 0", y, valid, busy, done);
        end
        step();
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_counter();
        ready = 1'b1;
        kick(2'd0, 8'd4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (!valid || y !== 16'(i)) begin
                bad++; $display("FAIL cnt_word%0d y=%h v=%b exp %h v=1", i, y, valid, 16'(i));
            end
            step();
        end
        total++;
        if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL cnt_done d=%b v=%b b=%b exp 1 0 1", done, valid, busy);
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || y !== 16'h0003) begin
            bad++; $display("FAIL cnt_idle d=%b b=%b y=%h exp 0 0 0003", done, busy, y);
        end
    endtask

    task automatic test_lfsr_backpressure();
        logic [15:0] exp_w [3] = '{16'hACE1, 16'hE270, 16'h7138};
        ready = 1'b0;
        kick(2'd1, 8'd3);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (!valid || y !== 16'hACE1) begin
                bad++; $display("FAIL lfsr_stall%0d y=%h v=%b exp ace1 v=1", i, y, valid);
            end
            step();
        end
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (!valid || y !== exp_w[i]) begin
                bad++; $display("FAIL lfsr_word%0d y=%h v=%b exp %h", i, y, valid, exp_w[i]);
            end
            step();
        end
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL lfsr_done d=%b exp 1", done);
        end
        step();
    endtask

    task automatic test_walk_checker();
        logic [15:0] e;
        kick(2'd2, 8'd17);
        for (int i = 0; i < 17; i++) begin
            e = (i < 16) ? (16'h1 << i) : 16'h0001;
            total++;
            if (!valid || y !== e) begin
                bad++; $display("FAIL walk_word%0d y=%h v=%b exp %h", i, y, valid, e);
            end
            step();
        end
        step();
        kick(2'd3, 8'd3);
        for (int i = 0; i < 3; i++) begin
            e = (i == 1) ? 16'h5555 : 16'hAAAA;
            total++;
            if (!valid || y !== e) begin
                bad++; $display("FAIL chk_word%0d y=%h v=%b exp %h", i, y, valid, e);
            end
            step();
        end
        step();
    endtask

    task automatic test_zero_len();
        int dones = 0, vals = 0;
        kick(2'd0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            dones += int'(done);
            vals  += int'(valid);
            step();
        end
        total++;
        if (dones != 1 || vals != 0 || y !== 16'hAAAA) begin
            bad++; $display("FAIL zero_len dones=%0d valids=%0d y=%h exp 1 0 aaaa", dones, vals, y);
        end
    endtask

    task automatic test_ignored_start();
        int cnt = 0;
        logic seen = 1'b0;
        kick(2'd0, 8'd3);
        for (int i = 0; i < 40 && !seen; i++) begin
            start = (i == 1);
            mode  = (i == 1) ? 2'd3 : 2'd0;
            len   = (i == 1) ? 8'd10 : 8'd3;
            if (valid) begin
                total++;
                if (y !== 16'(cnt)) begin
                    bad++; $display("FAIL ign_word%0d y=%h exp %h", cnt, y, 16'(cnt));
                end
                cnt++;
            end
            seen = done;
            step();
        end
        start = 1'b0;
        total++;
        if (!seen || cnt != 3) begin
            bad++; $display("FAIL ign_count seen=%b words=%0d exp 1 3", seen, cnt);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        kick(2'd0, 8'd10);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (y !== 16'h0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rst_mid y=%h v=%b b=%b d=%b exp 0", y, valid, busy, done);
        end
        step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            stray += int'(done) + int'(busy) + int'(valid);
        end
        total++;
        if (stray != 0) begin
            bad++; $display("FAIL rst_after stray=%0d exp 0", stray);
        end
    endtask

`ifdef PATTGEN_CHECK_EN
    task automatic test_check();
        kick(2'd0, 8'd4);
        repeat (6) step();
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL err_clean err=%b exp 0", err);
        end
        chk_bad = 1'b1;
        kick(2'd2, 8'd2);
        step();
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL err_set err=%b exp 1", err);
        end
        chk_bad = 1'b0;
        repeat (4) step();
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL err_sticky err=%b exp 1", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_counter();
        test_lfsr_backpressure();
        test_walk_checker();
        test_zero_len();
        test_ignored_start();
        test_reset_mid();
`ifdef PATTGEN_CHECK_EN
        test_check();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
